// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU round-robin scheduler.
// Optional feature macro: ALU_ARB_DIVZERO_EN (divide-by-zero short-circuit).
package alu_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StCapt,
      StResp
   } arb_state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;

   // Result the ALU returns for opcodes it does not decode.
   localparam logic [15:0] ALU_DEFAULT_RES = 16'h00AC;
   // Result reported when a divide by zero is short-circuited.
   localparam logic [15:0] DIVZERO_RES     = 16'hFFFF;

   function automatic logic is_div_zero(input logic [3:0] sel, input logic [7:0] b);
      return (sel == OP_DIV) && (b == 8'h00);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after last_grant+1.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_req
);

   // Rotating priority search; the first hit after last_grant wins.
   always_comb begin
      logic        found;
      int unsigned idx;
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found          = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered 8-bit ALU among NUM_REQ requesters, one operation at a time,
// returning tagged results on a single response channel.
// Optional feature macro: ALU_ARB_DIVZERO_EN -- when defined, OP_DIV with B=0 is not
// issued to the ALU and is answered directly with DIVZERO_RES and rsp_err=1.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   input  logic [NUM_REQ*4-1:0] req_sel,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [3:0]           alu_sel,
   input  logic [15:0]          alu_out,
   input  logic                 alu_carry,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_result,
   output logic                 rsp_carry,
   output logic                 rsp_err,
   output logic [15:0]          ops_done
);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [7:0]        alu_a_q, alu_a_d;
   logic [7:0]        alu_b_q, alu_b_d;
   logic [3:0]        alu_sel_q, alu_sel_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [15:0]       rsp_result_q, rsp_result_d;
   logic              rsp_carry_q, rsp_carry_d;
   logic              rsp_err_q, rsp_err_d;
   logic [15:0]       ops_done_q, ops_done_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               any_req;
   logic [7:0]         a_g, b_g;
   logic [3:0]         sel_g;
   logic               div_zero;
   logic               accept;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_req    (any_req)
   );

   assign a_g   = req_a[8*grant_idx +: 8];
   assign b_g   = req_b[8*grant_idx +: 8];
   assign sel_g = req_sel[4*grant_idx +: 4];

`ifdef ALU_ARB_DIVZERO_EN
   assign div_zero = is_div_zero(sel_g, b_g);
`else
   assign div_zero = 1'b0;
`endif

   // Ready only goes to a valid requester, so any request in IDLE is an accept.
   assign accept    = (state_q == StIdle) && any_req && !rst;
   assign req_ready = accept ? grant : '0;

   // Next-state and datapath load decisions for the four-phase operation cycle.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_err_d    = rsp_err_q;
      ops_done_d   = ops_done_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               last_grant_d = grant_idx;
               rsp_id_d     = grant_idx;
               if (div_zero) begin
                  // ALU registers deliberately keep their previous operands.
                  rsp_result_d = DIVZERO_RES;
                  rsp_carry_d  = 1'b0;
                  rsp_err_d    = 1'b1;
                  state_d      = StResp;
               end else begin
                  alu_a_d   = a_g;
                  alu_b_d   = b_g;
                  alu_sel_d = sel_g;
                  rsp_err_d = 1'b0;
                  state_d   = StExec;
               end
            end
         end
         StExec: state_d = StCapt;
         StCapt: begin
            rsp_result_d = alu_out;
            rsp_carry_d  = alu_carry;
            rsp_err_d    = 1'b0;
            state_d      = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               ops_done_d = ops_done_q + 16'd1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         ops_done_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_err_q    <= rsp_err_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_err    = rsp_err_q;
   assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an attached registered ALU model.
module tb_alu_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ*8-1:0] req_a = '0;
   logic [NUM_REQ*8-1:0] req_b = '0;
   logic [NUM_REQ*4-1:0] req_sel = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           alu_a, alu_b;
   logic [3:0]           alu_sel;
   logic [15:0]          alu_out;
   logic                 alu_carry;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic [ID_W-1:0]      rsp_id;
   logic [15:0]          rsp_result;
   logic                 rsp_carry, rsp_err;
   logic [15:0]          ops_done;

   alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sel    (req_sel),
      .req_ready  (req_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_carry  (alu_carry),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_err    (rsp_err),
      .ops_done   (ops_done)
   );

   always #5 clk = ~clk;

   // Reference ALU behaviour: returns {carry, result}.
   function automatic logic [16:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
      logic [8:0] t;
      case (s)
         4'h0: begin t = {1'b0, a} + {1'b0, b}; return {t[8], 8'h00, t[7:0]}; end
         4'h1: begin t = {1'b0, a} - {1'b0, b}; return {t[8], 8'h00, t[7:0]}; end
         4'h2: return {1'b0, 16'(a) * 16'(b)};
         4'h3: return (b == 8'h00) ? 17'h0 : {1'b0, 8'h00, a / b};
         default: return {1'b0, 16'h00AC};
      endcase
   endfunction

   function automatic bit expect_dz(input logic [3:0] s, input logic [7:0] b);
`ifdef ALU_ARB_DIVZERO_EN
      return (s == 4'h3) && (b == 8'h00);
`else
      return 1'b0;
`endif
   endfunction

   // The shared ALU instance: one register stage on its inputs.
   always_ff @(posedge clk) {alu_carry, alu_out} <= alu_ref(alu_a, alu_b, alu_sel);

   typedef struct {
      int          id;
      logic [15:0] res;
      logic        carry;
      logic        err;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  sel;
      int          due;
      bit          seen;
   } exp_t;

   exp_t        exp_q[$];
   int          grant_log[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   bit          m_free = 1'b1;
   int          m_last = NUM_REQ - 1;
   logic [15:0] ops_model = '0;
   logic [7:0]  m_a = '0, m_b = '0;
   logic [3:0]  m_sel = '0;
   logic [NUM_REQ-1:0] ready_s = '0;
   logic [NUM_REQ-1:0] last_acc = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Reference model plus monitor, sampled on the falling edge.
   always @(negedge clk) begin
      int g;
      logic [NUM_REQ-1:0] exp_rdy;
      logic [16:0] r;
      exp_t it;
      cyc++;
      ready_s = req_ready;
      if (rst) begin
         exp_q.delete();
         m_free = 1'b1;
         m_last = NUM_REQ - 1;
         ops_model = '0;
         m_a = '0;
         m_b = '0;
         m_sel = '0;
      end else begin
         g = -1;
         exp_rdy = '0;
         if (m_free) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               int i;
               i = (m_last + k) % NUM_REQ;
               if (g < 0 && req_valid[i]) g = i;
            end
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (g >= 0) begin
            it.id = g;
            it.seen = 1'b0;
            if (expect_dz(req_sel[g*4 +: 4], req_b[g*8 +: 8])) begin
               it.res = 16'hFFFF;
               it.carry = 1'b0;
               it.err = 1'b1;
               it.due = cyc + 1;
            end else begin
               r = alu_ref(req_a[g*8 +: 8], req_b[g*8 +: 8], req_sel[g*4 +: 4]);
               it.res = r[15:0];
               it.carry = r[16];
               it.err = 1'b0;
               it.due = cyc + 3;
               m_a = req_a[g*8 +: 8];
               m_b = req_b[g*8 +: 8];
               m_sel = req_sel[g*4 +: 4];
            end
            it.a = m_a;
            it.b = m_b;
            it.sel = m_sel;
            exp_q.push_back(it);
            grant_log.push_back(g);
            m_free = 1'b0;
            m_last = g;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
               if (!exp_q[0].seen) begin
                  check("rsp_latency", 32'(cyc), 32'(exp_q[0].due));
                  exp_q[0].seen = 1'b1;
               end
               check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
               check("rsp_result", 32'(rsp_result), 32'(exp_q[0].res));
               check("rsp_carry", 32'(rsp_carry), 32'(exp_q[0].carry));
               check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
               check("alu_a", 32'(alu_a), 32'(exp_q[0].a));
               check("alu_b", 32'(alu_b), 32'(exp_q[0].b));
               check("alu_sel", 32'(alu_sel), 32'(exp_q[0].sel));
               if (rsp_ready) begin
                  check("ops_done", 32'(ops_done), 32'(ops_model));
                  ops_model = ops_model + 16'd1;
                  void'(exp_q.pop_front());
                  m_free = 1'b1;
               end
            end
         end else if (exp_q.size() > 0 && !exp_q[0].seen && cyc > exp_q[0].due) begin
            check("rsp_late", 32'(rsp_valid), 32'd1);
            exp_q[0].seen = 1'b1;
         end
      end
   end

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] s);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
      req_sel[i*4 +: 4] = s;
      req_valid[i] = 1'b1;
   endtask

   task automatic rand_req(input int i);
      int unsigned k;
      logic [3:0] s;
      logic [7:0] b;
      k = $urandom_range(0, 9);
      b = 8'($urandom);
      if (k < 8) s = 4'(k / 2);
      else if (k == 8) s = 4'($urandom_range(4, 15));
      else begin
         s = 4'h3;
         b = 8'h00;
      end
      set_req(i, 8'($urandom), b, s);
   endtask

   // One clock of stimulus, driven just after the rising edge.
   task automatic step(input int pct, input bit gen_new, input bit hold, input bit withdraw);
      @(posedge clk);
      #1;
      last_acc = req_valid & ready_s;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (last_acc[i] && !hold) req_valid[i] = 1'b0;
         else if (req_valid[i] && !last_acc[i] && withdraw && $urandom_range(0, 19) == 0)
            req_valid[i] = 1'b0;
         if (!req_valid[i] && gen_new && $urandom_range(0, 3) == 0) rand_req(i);
      end
      rsp_ready = ($urandom_range(0, 99) < pct);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         if (exp_q.size() == 0 && req_valid == '0 && m_free) return;
         step(100, 1'b0, 1'b0, 1'b0);
      end
      check("idle_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(100, 1'b0, 1'b0, 1'b0);
      step(100, 1'b0, 1'b0, 1'b0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_sel", 32'(alu_sel), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_ops_done", 32'(ops_done), 32'd0);
      grant_log.delete();
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] ops_before;

      do_reset();

      // Single add from requester 0.
      set_req(0, 8'h0F, 8'h01, 4'h0);
      wait_idle();
      check("add_ops_done", 32'(ops_done), 32'd1);

      // Fairness: all requesters held valid.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i % 2 == 0) set_req(i, 8'h10, 8'h10, 4'h2);
         else set_req(i, 8'h05, 8'h03, 4'h1);
      end
      for (int n = 0; n < 200 && grant_log.size() < 5; n++) step(100, 1'b0, 1'b1, 1'b0);
      req_valid = '0;
      wait_idle();
      check("fair_count", 32'(grant_log.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < grant_log.size(); k++)
         check("fair_order", 32'(grant_log[k]), 32'(k % NUM_REQ));

      // Back-pressure: response held while rsp_ready stays low.
      ops_before = ops_model;
      set_req(0, 8'hC8, 8'h64, 4'h0);
      for (int n = 0; n < 14; n++) step(0, 1'b0, 1'b0, 1'b0);
      check("bp_held", 32'(rsp_valid), 32'd1);
      check("bp_ready_low", 32'(req_ready), 32'd0);
      wait_idle();
      check("bp_one_rsp", 32'(ops_done), 32'(ops_before + 16'd1));

      // Divide by zero from requester 2.
      set_req(2, 8'h20, 8'h00, 4'h3);
      wait_idle();

      // Reset while the operation sits in EXEC.
      set_req(1, 8'h33, 8'h11, 4'h0);
      last_acc = '0;
      for (int n = 0; n < 20 && !last_acc[1]; n++) step(100, 1'b0, 1'b0, 1'b0);
      check("mid_accept", 32'(last_acc[1]), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i + 1), 8'(i + 2), 4'h0);
      do_reset();
      wait_idle();
      check("post_rst_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

      // Randomized traffic with withdrawals and back-pressure.
      for (int n = 0; n < 1500; n++) step(70, 1'b1, 1'b0, 1'b1);
      wait_idle();

      // Counter wrap: preload near the top, then complete three operations.
      @(posedge clk);
      #1;
      force dut.ops_done_q = 16'hFFFE;
      ops_model = 16'hFFFE;
      #1;
      release dut.ops_done_q;
      for (int i = 0; i < 3; i++) set_req(i, 8'(i), 8'h01, 4'h0);
      wait_idle();
      check("ops_wrap", 32'(ops_done), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
